// File: rtl/instr_encoder_loader.sv
// Program loader: packs instruction fields into 32-bit words and writes them to memory via req/gnt.
// Optional ILLEGAL_OP_CHECK_EN drops opcodes 0 and >25 and flags them in a sticky err bit.
module instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written,
  output logic              err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       enc;
  logic              illegal;

  always_comb begin
    case (in_opcode)
      6'd1, 6'd2, 6'd3, 6'd4, 6'd7, 6'd8, 6'd22, 6'd24:
        enc = {in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
      6'd21, 6'd23:
        enc = {in_opcode, in_target};
      default:
        enc = {in_opcode, in_rs, in_rt, in_imm};
    endcase
  end

`ifdef ILLEGAL_OP_CHECK_EN
  assign illegal = (in_opcode == 6'd0) || (in_opcode > 6'd25);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d  = base_addr;
          rem_d  = count;
          wcnt_d = '0;
          err_d  = 1'b0;
          if (count == '0) done_d  = 1'b1;
          else             state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          // illegal opcodes are consumed but leave pointer and remaining untouched
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            wdata_d = enc;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (mem_gnt) begin
          ptr_d  = ptr_q + ADDR_W'(1);
          rem_d  = rem_q - CNT_W'(1);
          wcnt_d = wcnt_q + CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // all handshake outputs decode straight from state so reset drops them without a clock
  assign in_ready      = (state_q == S_ACCEPT);
  assign mem_req       = (state_q == S_WRITE);
  assign busy          = (state_q != S_IDLE);
  assign mem_addr      = ptr_q;
  assign mem_wdata     = wdata_q;
  assign done          = done_q;
  assign words_written = wcnt_q;
  assign err           = err_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Program loader and instruction encoder for the bubble-sort core. It accepts instruction fields over a valid/ready stream and packs each into a 32-bit instruction word in the format the core decodes. Each word is written into the shared instruction/data memory through a request/grant write port. A start command loads a base address and word count; the core is released once the done signal pulses.

Parameters:
ADDR_W, 10, memory word-address width (1024 words)
CNT_W, 11, width of word count; must equal ADDR_W+1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle command; sampled only in IDLE
base_addr  in  ADDR_W  first write address, latched on start
count  in  CNT_W  number of words to load (0..1024), latched on start
in_valid  in  1  field bundle valid
in_ready  out  1  block can accept a bundle
in_opcode  in  6  opcode
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_shamt  in  5  shamt field
in_funct  in  6  funct field
in_imm  in  16  immediate / branch offset, raw 16 bits
in_target  in  26  jump target
mem_req  out  1  write request
mem_gnt  in  1  write grant
mem_addr  out  ADDR_W  write address
mem_wdata  out  32  encoded instruction word
busy  out  1  high in ACCEPT and WRITE
done  out  1  one-cycle pulse when the load completes
words_written  out  CNT_W  granted writes since the last start
err  out  1  sticky error; cleared on start (see Optional Feature)

Behaviour:
- Reset, asynchronous: state goes to IDLE; all outputs go to 0 immediately, including mem_req. Any partial load is abandoned, and words already written stay in memory.
- Encoding is a pure function of the opcode:
  - R-type, opcodes 1,2,3,4,7,8,22,24: {op,rs,rt,rd,shamt,funct}.
  - J-type, opcodes 21,23: {op,target}.
  - All other opcodes are I-type: {op,rs,rt,imm}.
  - imm is passed through unmodified: no sign extension or range check.
- IDLE:
  - in_ready=0 and busy=0.
  - On start: latch base_addr into the write pointer and count into remaining; clear words_written and err.
  - If count==0, pulse done on the next cycle and stay in IDLE. Otherwise go to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - When in_valid&&in_ready: register the encoded word into mem_wdata and go to WRITE.
  - mem_req rises in the cycle after acceptance.
- WRITE:
  - in_ready=0 and mem_req=1; mem_addr and mem_wdata are held stable until the grant.
  - A grant counts in any cycle where mem_req&&mem_gnt.
  - On grant: pointer increments, wrapping 1023→0 modulo 2^ADDR_W; remaining decrements; words_written increments.
  - If remaining becomes 0: pulse done for one cycle, deassert mem_req, and go to IDLE. Otherwise go to ACCEPT.
- Throughput: at most one word per 2 cycles. in_ready is never high while mem_req is high.
- start while busy is ignored and has no side effects.
- mem_gnt while mem_req=0 is ignored.
- done and start in the same cycle: the new command is accepted, because the state is IDLE by then.

Optional Feature:
ILLEGAL_OP_CHECK_EN
- Defined:
  - An opcode of 0 or greater than 25 is accepted, since in_ready handshakes normally, but is not written.
  - err is set and stays high until the next start.
  - remaining and the pointer are unchanged, and the state stays in ACCEPT.
- Not defined: every opcode is encoded by the rules above (undefined opcodes as I-type), and err is tied to 0.

Test Plan:
1. Reset, then start base=0, count=1; send op=1, rs=12, rt=10, rd=12, shamt=0, funct=0; gnt held high → one write, mem_addr=0, mem_wdata=0x058A6000, then done pulse, words_written=1.
2. Start base=0, count=2; send addi op=5, rs=10, rt=11, imm=512, then j op=21, target=6 → writes 0x154B0200 at address 0 and 0x54000006 at address 1.
3. bne op=16, rs=1, rt=7, imm=0xFFF6 with mem_gnt held low for 5 cycles → mem_req high and address/data stable throughout; in_ready=0; a single write of 0x4027FFF6 lands when gnt rises.
4. Start base=1023, count=2 → writes go to addresses 1023 then 0. Pulsing start mid-load changes nothing. start with count=0 → done one cycle later with no mem_req.
5. Assert rst in WRITE with mem_req high → mem_req, busy and in_ready drop to 0 in the same cycle without a clock edge. After release, start loads normally.
6. With ILLEGAL_OP_CHECK_EN: count=1; send op=0, then op=5 → err=1, only one write (the addi), then done. Without the macro: op=0 is written as an I-type word.
